uart_rx_core: RTL and testbench

//  Serial receive front end of the UART. Feeds the register block's RxData/RxDone inputs.

---
 rtl/uart_rx_core_if.sv | 34 +++
 rtl/uart_rx_core.sv | 144 ++++++++++++++
 tb/tb_uart_rx_core.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - control, serial-line and byte-result signals of the UART receive core
interface uart_rx_core_if #(
    parameter int DIV_W = 16
);
    logic             RxEn;
    logic [DIV_W-1:0] BaudDiv;
    logic             Rx;
    logic [7:0]       RxData;
    logic             RxDone;
    logic             FrameErr;
    logic             Busy;

    // Register block / line side: drives control and the serial line, receives results
    modport master (
        output RxEn,
        output BaudDiv,
        output Rx,
        input  RxData,
        input  RxDone,
        input  FrameErr,
        input  Busy
    );

    // Receive core side
    modport slave (
        input  RxEn,
        input  BaudDiv,
        input  Rx,
        output RxData,
        output RxDone,
        output FrameErr,
        output Busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling 8N1 UART receive core with start-edge alignment
module uart_rx_core #(
    parameter int DIV_W = 16,
    parameter int OSR   = 16
) (
    input  logic          pClk,
    input  logic          pReset,
    uart_rx_core_if.slave bus
);
    localparam int S_W = $clog2(OSR);

    // Majority taps sit around the bit centre; the resolve tap is the last of the three
    localparam logic [S_W-1:0] S_TAP0 = S_W'(7);
    localparam logic [S_W-1:0] S_TAP1 = S_W'(8);
    localparam logic [S_W-1:0] S_RES  = S_W'(9);
    localparam logic [S_W-1:0] S_LAST = S_W'(OSR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic             rx_s_d;
    logic [DIV_W-1:0] cnt;
    logic [S_W-1:0]   s_cnt;
    logic [1:0]       samp;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       rx_data_r;
    logic             rx_done_r;
    logic             frame_err_r;

    logic             fall;
    logic             tick;
    logic             maj;

    // Falling edge seen on the synchronised line (previous high, now low)
    assign fall = rx_s_d & ~rx_s;

    // Oversample tick; the divider only runs outside IDLE so phase restarts at each start edge
    assign tick = (state != IDLE) && (cnt == bus.BaudDiv);

    // Majority of the two stored taps and the live third tap
    assign maj = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    assign bus.RxData   = rx_data_r;
    assign bus.RxDone   = rx_done_r;
    assign bus.FrameErr = frame_err_r;
    assign bus.Busy     = (state != IDLE);

    // Two-flop synchroniser plus one delayed copy for edge detection; idle level is high
    always_ff @(posedge pClk) begin
        if (pReset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= bus.Rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    // Receive FSM with tick divider, sample counter, shift register and registered results
    always_ff @(posedge pClk) begin
        if (pReset) begin
            state       <= IDLE;
            cnt         <= '0;
            s_cnt       <= '0;
            samp        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data_r   <= '0;
            rx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_done_r <= 1'b0;
            if (!bus.RxEn) begin
                // Disable aborts any frame in flight, including one completing this cycle
                state <= IDLE;
                cnt   <= '0;
                s_cnt <= '0;
            end else if (state == IDLE) begin
                cnt   <= '0;
                s_cnt <= '0;
                if (fall) begin
                    state <= START;
                end
            end else if (!tick) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt   <= '0;
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
                if (s_cnt == S_TAP0) begin
                    samp[0] <= rx_s;
                end
                if (s_cnt == S_TAP1) begin
                    samp[1] <= rx_s;
                end
                case (state)
                    START: begin
                        if (s_cnt == S_RES && maj) begin
                            // Start bit did not hold low through its centre: a glitch
                            state <= IDLE;
                            s_cnt <= '0;
                        end else if (s_cnt == S_LAST) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        if (s_cnt == S_RES) begin
                            shreg[bit_idx] <= maj;
                        end
                        if (s_cnt == S_LAST) begin
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        // Finish mid stop bit so the next start edge is never missed
                        if (s_cnt == S_RES) begin
                            rx_data_r   <= shreg;
                            frame_err_r <= ~maj;
                            rx_done_r   <= 1'b1;
                            state       <= IDLE;
                            s_cnt       <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core against a frame-level model
module tb_uart_rx_core;
    logic pClk;
    logic pReset;
    int   checks;
    int   errors;
    int   cyc;

    uart_rx_core_if #(.DIV_W(16)) bus ();

    uart_rx_core #(.DIV_W(16), .OSR(16)) dut (
        .pClk   (pClk),
        .pReset (pReset),
        .bus    (bus)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    always @(posedge pClk) cyc <= cyc + 1;

    // Observed RxDone events
    logic [7:0] d_q[$];
    logic       fe_q[$];
    logic       busy_q[$];
    int         cyc_q[$];

    always @(posedge pClk) begin
        #1;
        if (bus.RxDone === 1'b1) begin
            d_q.push_back(bus.RxData);
            fe_q.push_back(bus.FrameErr);
            busy_q.push_back(bus.Busy);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        d_q.delete();
        fe_q.delete();
        busy_q.delete();
        cyc_q.delete();
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.Rx = v;
        repeat (n) @(negedge pClk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
        drive_bit(stop, bc);
    endtask

    task automatic test_reset();
        pReset      = 1'b1;
        bus.RxEn    = 1'b1;
        bus.BaudDiv = '0;
        bus.Rx      = 1'b1;
        repeat (3) @(negedge pClk);
        checks++; if (bus.RxData !== 8'h00) begin errors++; $display("FAIL reset_rxdata got %h expected 00", bus.RxData); end
        checks++; if (bus.RxDone !== 1'b0) begin errors++; $display("FAIL reset_rxdone got %b expected 0", bus.RxDone); end
        checks++; if (bus.FrameErr !== 1'b0) begin errors++; $display("FAIL reset_frameerr got %b expected 0", bus.FrameErr); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.Busy); end
        pReset = 1'b0;
        repeat (4) @(negedge pClk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b expected 0", bus.Busy); end
    endtask

    task automatic test_glitch();
        logic saw;
        clear_mon();
        saw = 1'b0;
        bus.Rx = 1'b0;
        repeat (4) begin @(negedge pClk); saw = saw | bus.Busy; end
        bus.Rx = 1'b1;
        repeat (12) begin @(negedge pClk); saw = saw | bus.Busy; end
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse got %b expected 1", saw); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b expected 0", bus.Busy); end
        repeat (160) @(negedge pClk);
        checks++; if (d_q.size() !== 0) begin errors++; $display("FAIL glitch_no_done got %0d expected 0", d_q.size()); end
        checks++; if (bus.RxData !== 8'h00) begin errors++; $display("FAIL glitch_rxdata got %h expected 00", bus.RxData); end
    endtask

    task automatic test_single_frame();
        int t0;
        int lat;
        clear_mon();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 16);
        repeat (8) @(negedge pClk);
        checks++; if (d_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d expected 1", d_q.size()); end
        if (d_q.size() >= 1) begin
            lat = cyc_q[0] - t0;
            checks++; if (lat < 156 || lat > 158) begin errors++; $display("FAIL single_latency got %0d expected 156..158", lat); end
            checks++; if (d_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h expected a5", d_q[0]); end
            checks++; if (fe_q[0] !== 1'b0) begin errors++; $display("FAIL single_frameerr got %b expected 0", fe_q[0]); end
            checks++; if (busy_q[0] !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b expected 0", busy_q[0]); end
        end
        checks++; if (bus.RxData !== 8'hA5) begin errors++; $display("FAIL single_hold got %h expected a5", bus.RxData); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h3C, 1'b0, 16);
        drive_bit(1'b1, 32);
        send_frame(8'h00, 1'b1, 16);
        drive_bit(1'b1, 16);
        checks++; if (d_q.size() !== 2) begin errors++; $display("FAIL ferr_count got %0d expected 2", d_q.size()); end
        if (d_q.size() >= 2) begin
            checks++; if (d_q[0] !== 8'h3C) begin errors++; $display("FAIL ferr_data0 got %h expected 3c", d_q[0]); end
            checks++; if (fe_q[0] !== 1'b1) begin errors++; $display("FAIL ferr_flag0 got %b expected 1", fe_q[0]); end
            checks++; if (d_q[1] !== 8'h00) begin errors++; $display("FAIL ferr_data1 got %h expected 00", d_q[1]); end
            checks++; if (fe_q[1] !== 1'b0) begin errors++; $display("FAIL ferr_flag1 got %b expected 0", fe_q[1]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        bus.BaudDiv = 16'd3;
        @(negedge pClk);
        send_frame(8'h55, 1'b1, 64);
        send_frame(8'hAA, 1'b1, 64);
        drive_bit(1'b1, 64);
        checks++; if (d_q.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d expected 2", d_q.size()); end
        if (d_q.size() >= 2) begin
            checks++; if (d_q[0] !== 8'h55) begin errors++; $display("FAIL b2b_data0 got %h expected 55", d_q[0]); end
            checks++; if (d_q[1] !== 8'hAA) begin errors++; $display("FAIL b2b_data1 got %h expected aa", d_q[1]); end
            checks++; if ((fe_q[0] | fe_q[1]) !== 1'b0) begin errors++; $display("FAIL b2b_frameerr got %b%b expected 00", fe_q[0], fe_q[1]); end
        end
        bus.BaudDiv = '0;
        @(negedge pClk);
    endtask

    task automatic test_abort_en();
        logic [7:0] v;
        clear_mon();
        v = 8'hF0;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(v[i], 16);
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL abort_en_busy_mid got %b expected 1", bus.Busy); end
        bus.RxEn = 1'b0;
        @(negedge pClk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_en_busy got %b expected 0", bus.Busy); end
        bus.Rx = 1'b1;
        repeat (200) @(negedge pClk);
        checks++; if (d_q.size() !== 0) begin errors++; $display("FAIL abort_en_no_done got %0d expected 0", d_q.size()); end
        checks++; if (bus.RxData !== 8'hAA) begin errors++; $display("FAIL abort_en_rxdata got %h expected aa", bus.RxData); end
        checks++; if (bus.FrameErr !== 1'b0) begin errors++; $display("FAIL abort_en_frameerr got %b expected 0", bus.FrameErr); end
        bus.RxEn = 1'b1;
        @(negedge pClk);
    endtask

    task automatic test_abort_reset();
        logic [7:0] v;
        clear_mon();
        v = 8'hF0;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(v[i], 16);
        pReset = 1'b1;
        bus.Rx = 1'b1;
        @(negedge pClk);
        pReset = 1'b0;
        @(negedge pClk);
        checks++; if (bus.RxData !== 8'h00) begin errors++; $display("FAIL abort_rst_rxdata got %h expected 00", bus.RxData); end
        checks++; if (bus.FrameErr !== 1'b0) begin errors++; $display("FAIL abort_rst_frameerr got %b expected 0", bus.FrameErr); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_rst_busy got %b expected 0", bus.Busy); end
        checks++; if (bus.RxDone !== 1'b0) begin errors++; $display("FAIL abort_rst_rxdone got %b expected 0", bus.RxDone); end
        repeat (200) @(negedge pClk);
        checks++; if (d_q.size() !== 0) begin errors++; $display("FAIL abort_rst_no_done got %0d expected 0", d_q.size()); end
    endtask

    task automatic test_break();
        clear_mon();
        drive_bit(1'b0, 320);
        checks++; if (d_q.size() !== 1) begin errors++; $display("FAIL break_count got %0d expected 1", d_q.size()); end
        if (d_q.size() >= 1) begin
            checks++; if (d_q[0] !== 8'h00) begin errors++; $display("FAIL break_data got %h expected 00", d_q[0]); end
            checks++; if (fe_q[0] !== 1'b1) begin errors++; $display("FAIL break_frameerr got %b expected 1", fe_q[0]); end
        end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL break_busy_low got %b expected 0", bus.Busy); end
        drive_bit(1'b1, 64);
        checks++; if (d_q.size() !== 1) begin errors++; $display("FAIL break_release_count got %0d expected 1", d_q.size()); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL break_release_busy got %b expected 0", bus.Busy); end
    endtask

    task automatic test_random_frames();
        logic [7:0] exp_d[$];
        logic       exp_fe[$];
        logic [7:0] d;
        logic       stop;
        int         bd;
        int         bc;
        int         gap;
        clear_mon();
        for (int k = 0; k < 12; k++) begin
            bd   = $urandom_range(0, 1);
            bc   = (bd + 1) * 16;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            bus.BaudDiv = 16'(bd);
            send_frame(d, stop, bc);
            exp_d.push_back(d);
            exp_fe.push_back(~stop);
            gap = stop ? $urandom_range(0, bc) : bc;
            if (gap > 0) drive_bit(1'b1, gap);
        end
        drive_bit(1'b1, 64);
        checks++; if (d_q.size() !== exp_d.size()) begin errors++; $display("FAIL rand_count got %0d expected %0d", d_q.size(), exp_d.size()); end
        if (d_q.size() == exp_d.size()) begin
            for (int k = 0; k < exp_d.size(); k++) begin
                checks++; if (d_q[k] !== exp_d[k]) begin errors++; $display("FAIL rand_data[%0d] got %h expected %h", k, d_q[k], exp_d[k]); end
                checks++; if (fe_q[k] !== exp_fe[k]) begin errors++; $display("FAIL rand_frameerr[%0d] got %b expected %b", k, fe_q[k], exp_fe[k]); end
            end
        end
        checks++; if (bus.RxData !== exp_d[exp_d.size()-1]) begin errors++; $display("FAIL rand_hold got %h expected %h", bus.RxData, exp_d[exp_d.size()-1]); end
        checks++; if (bus.FrameErr !== exp_fe[exp_fe.size()-1]) begin errors++; $display("FAIL rand_fe_hold got %b expected %b", bus.FrameErr, exp_fe[exp_fe.size()-1]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        pReset = 1'b1;
        bus.RxEn    = 1'b1;
        bus.BaudDiv = '0;
        bus.Rx      = 1'b1;
        @(negedge pClk);
        test_reset();
        test_glitch();
        test_single_frame();
        test_frame_err();
        test_back_to_back();
        test_abort_en();
        test_abort_reset();
        test_break();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
